// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: opcode encoding and control FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low XLEN bits kept.
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            running;

    // done flags the cycle whose step is the last; acc is final after that edge
    assign done    = running && (cnt == CW'(XLEN - 1));
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle ops registered at accept, MUL via an
// iterative multiplier; the result register holds until the consumer takes it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd,
    output logic            out_z,
    output logic            out_err
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state;
    alu_state_e      state_next;
    logic            accept;
    logic            deliver;
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;
    logic            load_single;
    logic            load_mul;
    logic            op_legal;
    logic            eq;
    logic            mul_z;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] product;
    logic [SHW-1:0]  shamt;

    assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign deliver     = out_valid && out_ready;
    assign is_mul      = (in_op == 4'(OP_MUL)) && MUL_EN;
    assign mul_start   = accept && is_mul;
    assign load_single = accept && !is_mul;
    assign load_mul    = (state == DONE) && (!out_valid || out_ready);
    assign eq          = (in_rs1 == in_rs2);
    assign shamt       = in_rs2[SHW-1:0];

    // MUL with MUL_EN=0 lands in the illegal branch along with unused codes
    always_comb begin
        alu_res  = '0;
        op_legal = 1'b1;
        case (alu_op_e'(in_op))
            OP_ADD:  alu_res = in_rs1 + in_rs2;
            OP_SUB:  alu_res = in_rs1 - in_rs2;
            OP_AND:  alu_res = in_rs1 & in_rs2;
            OP_OR:   alu_res = in_rs1 | in_rs2;
            OP_XOR:  alu_res = in_rs1 ^ in_rs2;
            OP_SLT:  alu_res = XLEN'($signed(in_rs1) < $signed(in_rs2));
            OP_SLTU: alu_res = XLEN'(in_rs1 < in_rs2);
            OP_SLL:  alu_res = in_rs1 << shamt;
            OP_SRL:  alu_res = in_rs1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(in_rs1) >>> shamt);
            default: op_legal = 1'b0;
        endcase
    end

    alu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_rs1),
        .b       (in_rs2),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = BUSY;
            BUSY:    if (mul_done)  state_next = DONE;
            DONE:    if (load_mul)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A delivery clears out_valid unless a new result loads on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_z     <= 1'b0;
            out_err   <= 1'b0;
            mul_z     <= 1'b0;
        end else begin
            if (deliver) begin
                out_valid <= 1'b0;
            end
            if (load_single) begin
                out_valid <= 1'b1;
                out_rd    <= alu_res;
                out_z     <= eq;
                out_err   <= !op_legal;
            end else if (load_mul) begin
                out_valid <= 1'b1;
                out_rd    <= product;
                out_z     <= mul_z;
                out_err   <= 1'b0;
            end
            if (mul_start) begin
                mul_z <= eq;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32, MUL_EN=1).
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;
    logic        out_z;
    logic        out_err;

    int nChecks = 0;
    int nFail   = 0;

    alu_seq #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_z     (out_z),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        #1;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rd", out_rd, 32'd0);
        checkOutput("rst_out_z", 32'(out_z), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD wraps to zero
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        checkOutput("add_in_ready", 32'(in_ready), 32'd1);
        tick();
        idleInputs();
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_rd", out_rd, 32'd0);
        checkOutput("add_z", 32'(out_z), 32'd0);
        checkOutput("add_err", 32'(out_err), 32'd0);

        // back-to-back single-cycle ops, one result per cycle
        applyStimulus(OP_SUB, 32'd5, 32'd5);
        tick();
        checkOutput("sub_valid", 32'(out_valid), 32'd1);
        checkOutput("sub_rd", out_rd, 32'd0);
        checkOutput("sub_z", 32'(out_z), 32'd1);
        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        checkOutput("slt_rd", out_rd, 32'd1);
        checkOutput("slt_z", 32'(out_z), 32'd0);
        applyStimulus(OP_SRA, 32'h8000_0000, 32'h0000_0024);
        tick();
        checkOutput("sra_rd", out_rd, 32'hF800_0000);
        checkOutput("sra_valid", 32'(out_valid), 32'd1);
        applyStimulus(OP_SRL, 32'h8000_0000, 32'h0000_0004);
        tick();
        checkOutput("srl_rd", out_rd, 32'h0800_0000);
        applyStimulus(OP_SLL, 32'd1, 32'h0000_0021);
        tick();
        checkOutput("sll_rd", out_rd, 32'd2);
        idleInputs();
        tick();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_rd_hold", out_rd, 32'd2);

        // MUL: in_ready low 33 cycles, ADD held on in_valid waits
        applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0001);
        tick();
        applyStimulus(OP_ADD, 32'd7, 32'd8);
        n = 0;
        seen = 0;
        while (!in_ready && n < 100) begin
            if (out_valid) seen++;
            tick();
            n++;
        end
        checkOutput("mul_busy_cycles", 32'(n), 32'd33);
        checkOutput("mul_no_early_valid", 32'(seen), 32'd0);
        checkOutput("mul_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_rd", out_rd, 32'h0001_0000);
        checkOutput("mul_z", 32'(out_z), 32'd0);
        checkOutput("mul_err", 32'(out_err), 32'd0);
        tick();
        idleInputs();
        checkOutput("held_add_rd", out_rd, 32'd15);
        checkOutput("held_add_valid", 32'(out_valid), 32'd1);
        tick();

        // backpressure: result held, then replaced with no bubble
        out_ready = 1'b0;
        applyStimulus(OP_SLTU, 32'd1, 32'd2);
        tick();
        idleInputs();
        checkOutput("sltu_rd", out_rd, 32'd1);
        tick();
        tick();
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_rd", out_rd, 32'd1);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("xor_valid", 32'(out_valid), 32'd1);
        checkOutput("xor_rd", out_rd, 32'hFF00_FF00);

        // illegal opcode, then a legal op clears the error
        applyStimulus(4'hF, 32'd3, 32'd3);
        tick();
        checkOutput("ill_rd", out_rd, 32'd0);
        checkOutput("ill_err", 32'(out_err), 32'd1);
        checkOutput("ill_z", 32'(out_z), 32'd1);
        applyStimulus(OP_OR, 32'h0000_000F, 32'h0000_00F0);
        tick();
        idleInputs();
        checkOutput("or_rd", out_rd, 32'h0000_00FF);
        checkOutput("or_err", 32'(out_err), 32'd0);
        tick();

        // reset mid-MUL aborts with no stale result
        applyStimulus(OP_MUL, 32'd3, 32'd4);
        tick();
        idleInputs();
        repeat (10) tick();
        checkOutput("midmul_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || !in_ready) seen++;
        end
        checkOutput("no_stale_result", 32'(seen), 32'd0);
        applyStimulus(OP_ADD, 32'd2, 32'd3);
        tick();
        idleInputs();
        checkOutput("post_rst_add_rd", out_rd, 32'd5);
        checkOutput("post_rst_add_valid", 32'(out_valid), 32'd1);

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule
